// File: rtl/string_ctrl_pkg.sv
// Shared defaults and FSM state encoding for the string fetch scheduler.
package string_ctrl_pkg;
    localparam int STRING_NUM = 13;
    localparam int MAX_CHAR   = 11;
    localparam int CHAR_WIDTH = 5;
    localparam int SPACE_CODE = 28;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        LOAD,
        STREAM
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant, search starts just after last_grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int SW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SW-1:0]      last_grant,
    output logic [NUM_REQ-1:0] grant
);
    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_grant) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/string_fetch_sched.sv
// Arbitrates string requests, fetches the string word from ROM and streams it
// out one character per handshake, most-significant character first.
module string_fetch_sched #(
    parameter int STRING_NUM = string_ctrl_pkg::STRING_NUM,
    parameter int MAX_CHAR   = string_ctrl_pkg::MAX_CHAR,
    parameter int CHAR_WIDTH = string_ctrl_pkg::CHAR_WIDTH,
    parameter int NUM_REQ    = 4,
    localparam int AW = $clog2(STRING_NUM + 1),
    localparam int IW = $clog2(MAX_CHAR),
    localparam int SW = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*AW-1:0]          req_addr,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [AW-1:0]                  rom_addr,
    input  logic [CHAR_WIDTH*MAX_CHAR-1:0] rom_data,
    output logic                           char_valid,
    input  logic                           char_ready,
    output logic [CHAR_WIDTH-1:0]          char_data,
    output logic [IW-1:0]                  char_idx,
    output logic                           char_last,
    output logic [SW-1:0]                  char_src,
    output logic                           busy
);
    import string_ctrl_pkg::*;

    localparam int                    WW       = CHAR_WIDTH * MAX_CHAR;
    localparam logic [AW-1:0]         ID_LIMIT = AW'(STRING_NUM);
    localparam logic [IW-1:0]         LAST_IDX = IW'(MAX_CHAR - 1);
    localparam logic [CHAR_WIDTH-1:0] SPACE    = CHAR_WIDTH'(SPACE_CODE);

    state_t             state_q;
    logic [AW-1:0]      rom_addr_q;
    logic [SW-1:0]      src_q;
    logic [SW-1:0]      last_grant_q;
    logic [WW-1:0]      shift_q;
    logic [IW-1:0]      idx_q;

    logic [NUM_REQ-1:0] grant;
    logic [SW-1:0]      grant_idx_d;
    logic [AW-1:0]      addr_d;
    logic               accept;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign req_ready = (state_q == IDLE) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        grant_idx_d = '0;
        addr_d      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                grant_idx_d = SW'(k);
                addr_d      = req_addr[k*AW +: AW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rom_addr_q   <= '0;
            src_q        <= '0;
            last_grant_q <= SW'(NUM_REQ - 1);
            shift_q      <= '0;
            idx_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        rom_addr_q   <= addr_d;
                        src_q        <= grant_idx_d;
                        last_grant_q <= grant_idx_d;
                        state_q      <= ADDR;
                    end
                end
                // ROM is presented the address here; its word arrives next cycle
                ADDR: state_q <= LOAD;
                LOAD: begin
                    shift_q <= (rom_addr_q >= ID_LIMIT) ? {MAX_CHAR{SPACE}} : rom_data;
                    idx_q   <= '0;
                    state_q <= STREAM;
                end
                STREAM: begin
                    if (char_ready) begin
                        shift_q <= shift_q << CHAR_WIDTH;
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rom_addr   = rom_addr_q;
    assign char_valid = (state_q == STREAM);
    assign char_data  = shift_q[WW-1 -: CHAR_WIDTH];
    assign char_idx   = idx_q;
    assign char_last  = (idx_q == LAST_IDX);
    assign char_src   = src_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_string_fetch_sched.sv
// Self-checking bench: scoreboard of expected characters plus a vector table
// and hand-written arbitration, stall and reset sequences.
module tb_string_fetch_sched;
    localparam int NUM_REQ = 4;
    localparam int AW = 4;
    localparam int IW = 4;
    localparam int SW = 2;
    localparam int CW = 5;
    localparam int MC = 11;
    localparam int SN = 13;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ-1:0]    req_ready;
    logic [AW-1:0]         rom_addr;
    logic [CW*MC-1:0]      rom_data;
    logic                  char_valid;
    logic                  char_ready;
    logic [CW-1:0]         char_data;
    logic [IW-1:0]         char_idx;
    logic                  char_last;
    logic [SW-1:0]         char_src;
    logic                  busy;

    string_fetch_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .char_data  (char_data),
        .char_idx   (char_idx),
        .char_last  (char_last),
        .char_src   (char_src),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int               str_chars [SN][MC];
    logic [CW*MC-1:0] rom_word  [SN];

    // Synchronous ROM: word valid the cycle after the address; junk when out of range
    always @(posedge clk) rom_data <= (rom_addr < 4'd13) ? rom_word[rom_addr] : '1;

    typedef struct {
        int data;
        int idx;
        int src;
    } exp_t;

    typedef struct {
        int req;
        int addr;
        int stall;
        int exp_first;
        int exp_last;
    } vec_t;

    exp_t sb_q[$];
    int   grant_log[$];
    vec_t vecs[6];
    int   addr_m[NUM_REQ];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = -100;
    int lg_m = NUM_REQ - 1;
    bit busy_m = 1'b0;
    bit acc_seen = 1'b0;
    bit txn_done = 1'b0;
    int txn_first = -1;
    int txn_last = -1;
    bit prev_stall = 1'b0;
    int hold_data, hold_idx, hold_src, hold_last;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NUM_REQ-1:0] rr_model(input logic [NUM_REQ-1:0] v, input int lg);
        for (int i = 1; i <= NUM_REQ; i++) begin
            int k;
            k = (lg + i) % NUM_REQ;
            if (v[k]) return NUM_REQ'(1 << k);
        end
        return '0;
    endfunction

    function automatic int exp_char(input int a, input int i);
        if (a < SN) return str_chars[a][i];
        return 28;
    endfunction

    task automatic set_addrs();
        for (int k = 0; k < NUM_REQ; k++) req_addr[k*AW +: AW] = AW'(addr_m[k]);
    endtask

    // Samples at the falling edge what the next rising edge will act on
    task automatic monitor();
        int g;
        exp_t e;
        cyc++;
        if (rst) begin
            sb_q.delete();
            busy_m = 1'b0;
            lg_m = NUM_REQ - 1;
            prev_stall = 1'b0;
            return;
        end
        chk("req_ready", int'(req_ready), int'(busy_m ? 4'b0 : rr_model(req_valid, lg_m)));
        chk("busy", int'(busy), int'(busy_m));
        chk("char_valid", int'(char_valid), int'(busy_m && (cyc >= acc_cyc + 3)));
        if (prev_stall) begin
            chk("stall_data", int'(char_data), hold_data);
            chk("stall_idx", int'(char_idx), hold_idx);
            chk("stall_src", int'(char_src), hold_src);
            chk("stall_last", int'(char_last), hold_last);
        end
        if (char_valid) chk("char_last", int'(char_last), int'(char_idx == 4'd10));
        prev_stall = char_valid && !char_ready;
        hold_data = int'(char_data);
        hold_idx = int'(char_idx);
        hold_src = int'(char_src);
        hold_last = int'(char_last);
        if (char_valid && char_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("char_data", int'(char_data), e.data);
                chk("char_idx", int'(char_idx), e.idx);
                chk("char_src", int'(char_src), e.src);
                if (e.idx == 0) txn_first = int'(char_data);
                if (e.idx == MC - 1) begin
                    txn_last = int'(char_data);
                    busy_m = 1'b0;
                    txn_done = 1'b1;
                end
            end
        end
        g = -1;
        for (int k = 0; k < NUM_REQ; k++) if (req_valid[k] && req_ready[k]) g = k;
        if (g >= 0) begin
            grant_log.push_back(g);
            lg_m = g;
            busy_m = 1'b1;
            acc_cyc = cyc;
            acc_seen = 1'b1;
            txn_done = 1'b0;
            txn_first = -1;
            txn_last = -1;
            for (int i = 0; i < MC; i++) begin
                e.data = exp_char(addr_m[g], i);
                e.idx = i;
                e.src = g;
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input int bound);
        int n = 0;
        while (!acc_seen && n < bound) begin
            tick();
            n++;
        end
        chk("accept_seen", int'(acc_seen), 1);
    endtask

    task automatic wait_done(input int stall, input int bound);
        int n = 0;
        while (!txn_done && n < bound) begin
            char_ready = (stall != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        char_ready = 1'b1;
        chk("txn_done", int'(txn_done), 1);
        chk("sb_empty", sb_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        str_chars[0] = '{6, 0, 12, 4, 28, 19, 8, 12, 4, 26, 28};
        for (int a = 1; a < SN - 1; a++)
            for (int i = 0; i < MC; i++) str_chars[a][i] = (a * 5 + i * 3 + 1) % 32;
        str_chars[12] = '{8, 1, 2, 3, 4, 5, 6, 7, 9, 10, 13};
        for (int a = 0; a < SN; a++)
            for (int i = 0; i < MC; i++) rom_word[a][(MC-1-i)*CW +: CW] = CW'(str_chars[a][i]);

        vecs[0] = '{0, 0, 0, 6, 28};
        vecs[1] = '{1, 12, 0, 8, 13};
        vecs[2] = '{2, 13, 0, 28, 28};
        vecs[3] = '{3, 15, 1, 28, 28};
        vecs[4] = '{2, 0, 1, 6, 28};
        vecs[5] = '{0, 12, 1, 8, 13};

        for (int k = 0; k < NUM_REQ; k++) addr_m[k] = 0;
        set_addrs();
        char_ready = 1'b1;
        req_valid = '0;

        // Reset values
        rst = 1'b1;
        tick();
        tick();
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_char_valid", int'(char_valid), 0);
        chk("rst_char_data", int'(char_data), 0);
        chk("rst_char_idx", int'(char_idx), 0);
        chk("rst_char_last", int'(char_last), 0);
        chk("rst_char_src", int'(char_src), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;

        // Vector table: one requester per transaction
        for (int v = 0; v < 6; v++) begin
            addr_m[vecs[v].req] = vecs[v].addr;
            set_addrs();
            acc_seen = 1'b0;
            req_valid = NUM_REQ'(1 << vecs[v].req);
            wait_accept(10);
            req_valid = '0;
            wait_done(vecs[v].stall, 200);
            chk("vec_first", txn_first, vecs[v].exp_first);
            chk("vec_last", txn_last, vecs[v].exp_last);
        end

        // All requesters held valid after reset: rotation 0,1,2,3,0
        do_reset();
        addr_m = '{0, 12, 13, 5};
        set_addrs();
        grant_log.delete();
        begin
            int n = 0;
            req_valid = '1;
            while (grant_log.size() < 5 && n < 400) begin
                tick();
                n++;
            end
            req_valid = '0;
        end
        chk("rr_grants", grant_log.size(), 5);
        if (grant_log.size() >= 5) begin
            chk("rr_g0", grant_log[0], 0);
            chk("rr_g1", grant_log[1], 1);
            chk("rr_g2", grant_log[2], 2);
            chk("rr_g3", grant_log[3], 3);
            chk("rr_g4", grant_log[4], 0);
        end
        wait_done(0, 100);

        // Stall pattern 1,0,0,1 on the character stream
        addr_m[1] = 0;
        set_addrs();
        acc_seen = 1'b0;
        char_ready = 1'b0;
        req_valid = 4'b0010;
        wait_accept(10);
        req_valid = '0;
        begin
            int n = 0;
            while (!char_valid && n < 10) begin
                tick();
                n++;
            end
        end
        chk("stall_stream_up", int'(char_valid), 1);
        char_ready = 1'b1;
        tick();
        char_ready = 1'b0;
        tick();
        tick();
        chk("stall_idx_held", int'(char_idx), 1);
        char_ready = 1'b1;
        tick();
        wait_done(0, 50);
        chk("stall_first", txn_first, 6);
        chk("stall_last", txn_last, 28);

        // Reset on the 5th character, then priority back at requester 0
        addr_m[2] = 12;
        set_addrs();
        acc_seen = 1'b0;
        req_valid = 4'b0100;
        wait_accept(10);
        req_valid = '0;
        begin
            int n = 0;
            while (!(char_valid && char_idx == 4'd4) && n < 30) begin
                tick();
                n++;
            end
        end
        chk("mid_idx4", int'(char_idx), 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_char_valid", int'(char_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_char_idx", int'(char_idx), 0);
        addr_m[0] = 5;
        addr_m[3] = 7;
        set_addrs();
        grant_log.delete();
        acc_seen = 1'b0;
        req_valid = 4'b1001;
        wait_accept(10);
        req_valid = '0;
        chk("restart_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        wait_done(0, 50);
        chk("restart_first", txn_first, exp_char(5, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
